// File: rtl/i2c_cmd_master.sv
// i2c_cmd_master: command-driven multi-channel I2C master (optional clock stretching via I2C_STRETCH_EN)
module i2c_cmd_master #(
    parameter int CLK_DIV = 125,
    parameter int NUM_CH  = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_ch,
    input  logic [7:0]        cmd_data,
    input  logic              cmd_ack,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_nack,
    input  logic [NUM_CH-1:0] sda_in,
    input  logic [NUM_CH-1:0] scl_in,
    output logic [NUM_CH-1:0] sda_oe,
    output logic [NUM_CH-1:0] scl_oe
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [2:0] NCH = 3'(NUM_CH);
    typedef enum logic [2:0] {IDLE, START, BIT, ACKBIT, STOP, DONE} state_t;
    state_t state, ent_st;
    logic [CW-1:0] cnt;
    logic [1:0] q, ch, ent_q, ch_e;
    logic [2:0] bit_i, ent_bit;
    logic [7:0] data_r, sh, ent_data;
    logic rd_r, ak_r, nk, ent_rd, ent_ak, v, fire, legal, cnt_last, q_end, freeze, sda_sel;
    logic [3:0] a;
    // line action on entering quarter qq of state s: {sda_en, sda_val, scl_en, scl_val}
    function automatic logic [3:0] act(state_t s, logic [1:0] qq, logic b);
        return qq == 2'd0 ? (s == START ? 4'b1000 : s == STOP ? 4'b1100 : {1'b1, b, 2'b11}) :
               qq == 2'd1 ? 4'b0010 :
               qq == 2'd2 ? (s == START ? 4'b1100 : s == STOP ? 4'b1000 : 4'b0000) :
               (s == STOP ? 4'b0000 : 4'b0011);
    endfunction
    // selected channel's SDA level
    always_comb begin
        sda_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch == 2'(i)) sda_sel = sda_in[i];
    end
`ifdef I2C_STRETCH_EN
    logic scl_sel;
    // selected channel's SCL level; a low SCL while released freezes the quarter counter
    always_comb begin
        scl_sel = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (ch == 2'(i)) scl_sel = scl_in[i];
    end
    assign freeze = (q == 2'd1 || q == 2'd2) && !scl_sel;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, scl_in};
    assign freeze = 1'b0;
`endif
    assign legal    = cmd_op <= 3'd3 && {1'b0, cmd_ch} < NCH;
    assign cnt_last = cnt == CW'(CLK_DIV - 1);
    assign q_end    = cnt_last && !freeze;
    // state/quarter/bit being entered next and the line action that goes with it
    always_comb begin
        ent_st   = state == IDLE ? (!legal ? DONE : cmd_op == 3'd0 ? START : cmd_op == 3'd3 ? STOP : BIT) :
                   q != 2'd3 ? state : (state == BIT && bit_i != 3'd7) ? BIT : state == BIT ? ACKBIT : IDLE;
        ent_q    = state == IDLE ? 2'd0 : q + 2'd1;
        ent_bit  = state == IDLE ? 3'd0 : q == 2'd3 ? bit_i + 3'd1 : bit_i;
        ent_data = state == IDLE ? cmd_data : data_r;
        ent_rd   = state == IDLE ? cmd_op == 3'd2 : rd_r;
        ent_ak   = state == IDLE ? cmd_ack : ak_r;
        ch_e     = state == IDLE ? cmd_ch : ch;
        v        = ent_st == ACKBIT ? ent_rd & ent_ak : !ent_rd & !ent_data[3'd7 - ent_bit];
        a        = act(ent_st, ent_q, v);
        fire     = state == IDLE ? cmd_valid && cmd_ready && legal : state != DONE && q_end && ent_st != IDLE;
    end
    // command FSM, quarter timing, line drivers and response registers
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE; cnt <= '0; q <= 2'd0; bit_i <= 3'd0; ch <= 2'd0;
            data_r <= 8'd0; rd_r <= 1'b0; ak_r <= 1'b0; sh <= 8'd0; nk <= 1'b0;
            cmd_ready <= 1'b1; rsp_valid <= 1'b0; rsp_data <= 8'd0; rsp_nack <= 1'b0;
            sda_oe <= '0; scl_oe <= '0;
        end else begin
            rsp_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                if (fire && ch_e == 2'(i)) begin
                    if (a[3]) sda_oe[i] <= a[2];
                    if (a[1]) scl_oe[i] <= a[0];
                end
            if (state == IDLE) begin
                if (cmd_valid && cmd_ready) begin
                    state <= ent_st; cmd_ready <= 1'b0; cnt <= '0; q <= 2'd0; bit_i <= 3'd0;
                    ch <= cmd_ch; data_r <= cmd_data; rd_r <= cmd_op == 3'd2; ak_r <= cmd_ack;
                end
            end else if (state == DONE) begin
                state <= IDLE; cmd_ready <= 1'b1; rsp_valid <= 1'b1; rsp_data <= 8'd0; rsp_nack <= 1'b1;
            end else if (!freeze) begin
                cnt <= cnt_last ? '0 : cnt + CW'(1);
                if (cnt_last) begin
                    q <= ent_q; bit_i <= ent_bit; state <= ent_st;
                    if (q == 2'd2 && state == BIT) sh <= {sh[6:0], sda_sel};
                    if (q == 2'd2) nk <= sda_sel;
                    if (ent_st == IDLE) begin
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= (state == ACKBIT && rd_r) ? sh : 8'd0;
                        rsp_nack  <= state == ACKBIT && !rd_r && nk;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_cmd_master.sv
// tb_i2c_cmd_master: directed bench for i2c_cmd_master with CLK_DIV=4, NUM_CH=2
module tb_i2c_cmd_master;
    logic clk = 1'b0, rst = 1'b0, cmd_valid = 1'b0, cmd_ack = 1'b0;
    logic cmd_ready, rsp_valid, rsp_nack;
    logic [2:0] cmd_op = 3'd0;
    logic [1:0] cmd_ch = 2'd0;
    logic [7:0] cmd_data = 8'd0, rsp_data, slave_byte = 8'd0;
    logic [1:0] sda_in, scl_in, sda_oe, scl_oe, slave_low = 2'b00, scl_hold = 2'b00;
    int errs = 0, checks = 0, cyc = 0, rsp_cyc = 0, slave_mode = 0, slave_ch = 0, hold_from = 0, hold_to = 0;

    assign sda_in = ~(sda_oe | slave_low);
    assign scl_in = ~(scl_oe | scl_hold);

    i2c_cmd_master #(.CLK_DIV(4), .NUM_CH(2)) dut (
        .clk_clk(clk), .reset_reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
        .sda_in(sda_in), .scl_in(scl_in), .sda_oe(sda_oe), .scl_oe(scl_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one cycle: advance to negedge, update slave model, record first rsp_valid cycle
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
            if ((cyc - 1) % 16 == 0) begin
                if (slave_mode == 1 && (cyc - 1) / 16 < 8)
                    slave_low[slave_ch] = ~slave_byte[7 - (cyc - 1) / 16];
                else
                    slave_low[slave_ch] = (slave_mode == 2 && (cyc - 1) / 16 == 8);
            end
            scl_hold[0] = (cyc >= hold_from && cyc < hold_to);
            if (rsp_valid && rsp_cyc == 0) rsp_cyc = cyc;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [1:0] ch, input logic [7:0] d, input logic ak);
        @(negedge clk);
        cmd_op = op; cmd_ch = ch; cmd_data = d; cmd_ack = ak; cmd_valid = 1'b1;
        chk("ready_before_send", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        cyc = 0; rsp_cyc = 0;
    endtask

    initial begin
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        chk("rst_sda_oe", {30'd0, sda_oe}, 32'd0);
        chk("rst_scl_oe", {30'd0, scl_oe}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_rsp_nack", {31'd0, rsp_nack}, 32'd0);

        // START on ch0
        send(3'd0, 2'd0, 8'h00, 1'b0);
        step(8);  chk("start_sda_c8", {31'd0, sda_oe[0]}, 32'd0);
        step(1);  chk("start_sda_c9", {31'd0, sda_oe[0]}, 32'd1);
        step(3);  chk("start_scl_c12", {31'd0, scl_oe[0]}, 32'd0);
        step(1);  chk("start_scl_c13", {31'd0, scl_oe[0]}, 32'd1);
        step(3);  chk("start_ready_c16", {31'd0, cmd_ready}, 32'd0);
        step(1);  chk("start_ready_c17", {31'd0, cmd_ready}, 32'd1);
        chk("start_rsp_cyc", rsp_cyc, 17);
        chk("start_ch1_sda", {31'd0, sda_oe[1]}, 32'd0);
        chk("start_ch1_scl", {31'd0, scl_oe[1]}, 32'd0);

        // WRITE 0x34 on ch0, slave ACKs
        slave_mode = 2; slave_ch = 0;
        send(3'd1, 2'd0, 8'h34, 1'b0);
        for (int b = 0; b < 8; b++) begin
            step(8);
            chk($sformatf("wr34_bit%0d", b), {31'd0, sda_oe[0]}, {31'd0, ~(b == 2 || b == 3 || b == 5)});
            step(8);
        end
        step(20);
        chk("wr34_rsp_cyc", rsp_cyc, 145);
        chk("wr34_nack", {31'd0, rsp_nack}, 32'd0);
        chk("wr34_data", {24'd0, rsp_data}, 32'd0);

        // WRITE 0xFF on ch0, no slave ACK
        slave_mode = 0;
        send(3'd1, 2'd0, 8'hFF, 1'b0);
        step(150);
        chk("wrff_rsp_cyc", rsp_cyc, 145);
        chk("wrff_nack", {31'd0, rsp_nack}, 32'd1);

        // READ on ch1, slave sends 0xA5, master NACKs
        slave_mode = 1; slave_ch = 1; slave_byte = 8'hA5;
        send(3'd2, 2'd1, 8'h00, 1'b0);
        step(130); chk("rdA5_ack_c130", {31'd0, sda_oe[1]}, 32'd0);
        chk("rdA5_ch0_sda", {31'd0, sda_oe[0]}, 32'd0);
        chk("rdA5_ch0_scl", {31'd0, scl_oe[0]}, 32'd1);
        step(14); chk("rdA5_ack_c144", {31'd0, sda_oe[1]}, 32'd0);
        step(6);
        chk("rdA5_rsp_cyc", rsp_cyc, 145);
        chk("rdA5_data", {24'd0, rsp_data}, 32'hA5);
        chk("rdA5_nack", {31'd0, rsp_nack}, 32'd0);

        // READ on ch1, slave sends 0x5A, master ACKs
        slave_byte = 8'h5A;
        send(3'd2, 2'd1, 8'h00, 1'b1);
        step(136); chk("rd5A_ack_c136", {31'd0, sda_oe[1]}, 32'd1);
        step(14);
        chk("rd5A_data", {24'd0, rsp_data}, 32'h5A);
        slave_mode = 0;

        // illegal op and illegal channel
        send(3'd5, 2'd0, 8'h00, 1'b0);
        step(4);
        chk("ill_op_rsp_cyc", rsp_cyc, 2);
        chk("ill_op_nack", {31'd0, rsp_nack}, 32'd1);
        chk("ill_op_sda", {30'd0, sda_oe}, 32'h2);
        chk("ill_op_scl", {30'd0, scl_oe}, 32'h3);
        send(3'd1, 2'd3, 8'h00, 1'b0);
        step(4);
        chk("ill_ch_rsp_cyc", rsp_cyc, 2);
        chk("ill_ch_nack", {31'd0, rsp_nack}, 32'd1);
        chk("ill_ch_data", {24'd0, rsp_data}, 32'd0);
        chk("ill_ch_sda", {30'd0, sda_oe}, 32'h2);
        chk("ill_ch_scl", {30'd0, scl_oe}, 32'h3);

        // WRITE with SCL held low by the slave for 20 cycles in bit 3
        slave_mode = 2; slave_ch = 0; hold_from = 53; hold_to = 73;
        send(3'd1, 2'd0, 8'h00, 1'b0);
        step(180);
`ifdef I2C_STRETCH_EN
        chk("stretch_rsp_cyc", rsp_cyc, 165);
`else
        chk("stretch_rsp_cyc", rsp_cyc, 145);
`endif
        chk("stretch_nack", {31'd0, rsp_nack}, 32'd0);
        slave_mode = 0; hold_from = 0; hold_to = 0;

        // STOP on ch0
        send(3'd3, 2'd0, 8'h00, 1'b0);
        step(20);
        chk("stop_rsp_cyc", rsp_cyc, 17);
        chk("stop_sda", {31'd0, sda_oe[0]}, 32'd0);
        chk("stop_scl", {31'd0, scl_oe[0]}, 32'd0);

        // reset in the middle of a WRITE on ch1
        send(3'd1, 2'd1, 8'h00, 1'b0);
        step(40);
        chk("midrst_busy", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_sda", {30'd0, sda_oe}, 32'd0);
        chk("midrst_scl", {30'd0, scl_oe}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        step(200);
        chk("midrst_no_rsp", rsp_cyc, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_master.md
I2C_CMD_MASTER -- requirements
Module: i2c_cmd_master

Interface
REQ-001 Parameter CLK_DIV, default 125; clk_clk cycles per SCL quarter-period; legal values are 2 or more.
REQ-002 Parameter NUM_CH, default 2; number of independent open-drain I2C buses; legal values are 1 to 4.
REQ-003 Port clk_clk, input, 1 bit; the single clock; all logic is rising-edge.
REQ-004 Port reset_reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 Port cmd_valid, input, 1 bit; a command is offered.
REQ-006 Port cmd_ready, output, 1 bit; the block accepts a command this cycle.
REQ-007 Port cmd_op, input, 3 bits; command code: 0 START, 1 WRITE, 2 READ, 3 STOP, 4-7 illegal.
REQ-008 Port cmd_ch, input, 2 bits; target bus index.
REQ-009 Port cmd_data, input, 8 bits; WRITE byte, sent MSB first.
REQ-010 Port cmd_ack, input, 1 bit; for READ, 1 = master drives ACK, 0 = NACK.
REQ-011 Port rsp_valid, output, 1 bit; one-cycle completion pulse.
REQ-012 Port rsp_data, output, 8 bits; byte received by READ, otherwise 0.
REQ-013 Port rsp_nack, output, 1 bit; WRITE: sampled slave ACK bit; illegal op: 1; otherwise 0.
REQ-014 Ports sda_in and scl_in, inputs, NUM_CH bits each; sampled line levels.
REQ-015 Ports sda_oe and scl_oe, outputs, NUM_CH bits each; 1 pulls the line low, 0 releases it.

Function
REQ-016 Handshake: a command is accepted on a cycle where cmd_valid and cmd_ready are both 1 (cycle T); all command fields are latched at T.
REQ-017 cmd_ready is 1 only in IDLE and goes 0 on T+1; it returns to 1 on the same cycle as rsp_valid.
REQ-018 Timing base: a quarter counter counts 0 to CLK_DIV-1; each legal operation is a whole number Q of quarters.
REQ-019 Completion timing: the operation ends at T+Q*CLK_DIV; rsp_valid=1 at T+Q*CLK_DIV+1, before any stretch delay is added.
REQ-020 FSM states are IDLE, START, BIT, ACKBIT, STOP and DONE; DONE lasts one cycle and returns to IDLE.
REQ-021 START (Q=4): quarter q0 releases SDA; q1 releases SCL; q2 pulls SDA low; q3 pulls SCL low. The same sequence serves as a repeated start.
REQ-022 WRITE (Q=36): 8 data bits then an ACK bit.
  - Each bit: q0 sets SDA (sda_oe = inverse of the bit) with SCL held low; q1 and q2 release SCL; q3 pulls SCL low.
  - ACK bit: SDA released; rsp_nack = sda_in sampled on the last cycle of q2.
REQ-023 READ (Q=36): SDA released for 8 bits; each bit is sampled on the last cycle of q2 and shifted in MSB first. In the 9th bit, sda_oe = cmd_ack.
REQ-024 STOP (Q=4): q0 pulls SDA low; q1 releases SCL; q2 releases SDA; q3 idles.
REQ-025 Illegal op (4-7): no line changes; rsp_valid=1 at T+2 with rsp_nack=1.
REQ-026 cmd_ch at or above NUM_CH is treated as an illegal op.
REQ-027 Non-selected channels hold their last sda_oe and scl_oe values unchanged.
REQ-028 Only the selected channel's sda_in and scl_in are observed.
REQ-029 rsp_data and rsp_nack hold their value until the next rsp_valid.

Reset
REQ-030 On reset, all outputs take these values on the next edge, whatever state the FSM is in:
  - sda_oe = 0, scl_oe = 0
  - cmd_ready = 1
  - rsp_valid = 0, rsp_data = 0, rsp_nack = 0
  - FSM = IDLE, counters = 0
REQ-031 Reset during an operation aborts it with no rsp_valid, and cmd_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-032 Macro I2C_STRETCH_EN: when defined, the quarter counter freezes in q1 and q2 while the selected scl_in is 0; each frozen cycle extends completion by one cycle.
REQ-033 Without I2C_STRETCH_EN, scl_in is ignored and timing follows REQ-019 exactly.

Verification (CLK_DIV=4, NUM_CH=2)
REQ-034 Assert reset for 3 cycles -> sda_oe=00, scl_oe=00, cmd_ready=1, rsp_valid=0.
REQ-035 START on ch0 accepted at T -> sda_oe[0] rises at T+9, scl_oe[0] rises at T+13, rsp_valid at T+17, ch1 lines untouched.
REQ-036 WRITE 0x34 on ch0 with the slave pulling SDA low in the ACK bit -> sda_oe[0] per bit is 1,1,0,0,1,0,1,1; rsp_nack=0; rsp_valid at T+145.
REQ-037 READ on ch1 with the slave driving 0xA5 and cmd_ack=0 -> rsp_data=0xA5, rsp_nack=0, sda_oe[1]=0 throughout the 9th bit.
REQ-038 cmd_op=5, then cmd_ch=3 -> each gives rsp_valid at T+2 with rsp_nack=1 and no oe change; a reset asserted mid-WRITE -> all oe 0, no rsp_valid.
REQ-039 Hold scl_in[0]=0 for 20 cycles during bit 3 of a WRITE -> rsp_valid at T+165 with I2C_STRETCH_EN, T+145 without.
